sram_frame_reader: RTL



---
 rtl/sram_frame_pkg.sv | 25 ++
 rtl/sram_word_fetch.sv | 49 ++++
 rtl/sram_frame_reader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sram_frame_pkg.sv
// Shared framing constants and FSM state encoding for the SRAM transmit FIFO.
// Used by both the SPI-side writer and the radio-side frame reader.
package sram_frame_pkg;
  localparam int          WORD_W       = 16;
  localparam int          BYTE_W       = 8;
  localparam logic [15:0] SYNC_WORD    = 16'h2DD4;
  localparam int          HINT_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_SYNC,
    ST_FETCH_LEN,
    ST_FETCH_DATA,
    ST_EMIT_HI,
    ST_EMIT_LO,
    ST_DONE
  } state_t;

  // Words needed to carry n bytes packed two per word.
  function automatic logic [7:0] words_for_bytes(input logic [7:0] n);
    logic [8:0] t;
    t = {1'b0, n} + 9'd1;
    return t[8:1];
  endfunction
endpackage

// File: rtl/sram_word_fetch.sv
// Single-word read handshake with the SRAM FIFO: request rises the cycle after req && !empty,
// holds until hint (word valid that cycle, combinational), never re-requests on the hint cycle, aborts on timeout.
module sram_word_fetch
  import sram_frame_pkg::*;
#(
  parameter int TIMEOUT = HINT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              sram_empty,
  input  logic              sram_hint,
  input  logic [WORD_W-1:0] sram_data,
  output logic              sram_read,
  output logic [WORD_W-1:0] word,
  output logic              word_vld,
  output logic              timeout
);
  localparam int CNT_W = $clog2(TIMEOUT);

  logic             read_q, read_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      read_q <= read_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    word_vld = read_q && sram_hint;
    timeout  = read_q && !sram_hint && (cnt_q == CNT_W'(TIMEOUT - 1));
    read_d   = 1'b0;
    cnt_d    = '0;
    if (read_q) begin
      read_d = !sram_hint && !timeout;
      if (read_d) cnt_d = cnt_q + 1'b1;
    end else begin
      read_d = req && !sram_empty;
    end
  end

  assign sram_read = read_q;
  assign word      = sram_data;
endmodule

// File: rtl/sram_frame_reader.sv
// Hunts sync, validates length header and unpacks SRAM FIFO words into a byte stream.
// One word in flight at a time; the next word is fetched only after both bytes of the current one transfer.
module sram_frame_reader
  import sram_frame_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic              SRAM_read,
  input  logic              SRAM_hint,
  input  logic [WORD_W-1:0] Data_from_sram,
  input  logic              SRAM_empty,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sof,
  output logic              tx_eof,
  output logic [BYTE_W-1:0] frame_len,
  output logic              frame_done,
  output logic              frame_drop,
  output logic              sync_err
);
  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [7:0]        n_q, n_d, len_q, len_d, cnt_q, cnt_d, left_q, left_d;
  logic              first_q, first_d, skip_q, skip_d, drop_q, drop_d, serr_q, serr_d;
  logic              fetch_req, word_vld, fetch_tmo, last_byte;
  logic [WORD_W-1:0] word;

  assign fetch_req = (state_q == ST_FETCH_SYNC) || (state_q == ST_FETCH_LEN) ||
                     (state_q == ST_FETCH_DATA);
  assign last_byte = (cnt_q == len_q - 8'd1);

  sram_word_fetch u_fetch (
    .clk        (clk),
    .reset      (reset),
    .req        (fetch_req),
    .sram_empty (SRAM_empty),
    .sram_hint  (SRAM_hint),
    .sram_data  (Data_from_sram),
    .sram_read  (SRAM_read),
    .word       (word),
    .word_vld   (word_vld),
    .timeout    (fetch_tmo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      n_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      first_q <= 1'b0;
      skip_q  <= 1'b0;
      drop_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      n_q     <= n_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      first_q <= first_d;
      skip_q  <= skip_d;
      drop_q  <= drop_d;
      serr_q  <= serr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    n_d     = n_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    first_d = first_q;
    skip_d  = skip_q;
    drop_d  = 1'b0;
    serr_d  = 1'b0;
    if (fetch_req && fetch_tmo) begin
      drop_d  = 1'b1;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (!SRAM_empty) state_d = ST_FETCH_SYNC;
        ST_FETCH_SYNC: if (word_vld) begin
          if (word == SYNC_WORD) state_d = ST_FETCH_LEN;
          else begin
            serr_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_FETCH_LEN: if (word_vld) begin
          n_d = word[7:0];
          if (word[15:8] != 8'h00 || word[7:0] == 8'h00) begin
            drop_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            left_d  = words_for_bytes(word[7:0]);
            first_d = 1'b1;
            skip_d  = 1'b0;
            state_d = ST_FETCH_DATA;
          end
        end
        ST_FETCH_DATA: if (word_vld) begin
          word_d = word;
          left_d = left_q - 8'd1;
          if (skip_q) begin
            if (left_q == 8'd1) state_d = ST_IDLE;
          end else if (first_q) begin
            first_d = 1'b0;
            // Inner length byte must agree with the header, otherwise drain the rest of the frame.
            if (word[15:8] != n_q - 8'd1) begin
              drop_d = 1'b1;
              if (left_q == 8'd1) state_d = ST_IDLE;
              else skip_d = 1'b1;
            end else if (word[15:8] == 8'h00) begin
              drop_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              len_d   = word[15:8];
              cnt_d   = 8'd0;
              state_d = ST_EMIT_LO;
            end
          end else begin
            state_d = ST_EMIT_HI;
          end
        end
        ST_EMIT_HI: if (tx_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = last_byte ? ST_DONE : ST_EMIT_LO;
        end
        ST_EMIT_LO: if (tx_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = last_byte ? ST_DONE : ST_FETCH_DATA;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_valid   = (state_q == ST_EMIT_HI) || (state_q == ST_EMIT_LO);
    tx_data    = '0;
    if (state_q == ST_EMIT_HI) tx_data = word_q[15:8];
    if (state_q == ST_EMIT_LO) tx_data = word_q[7:0];
    tx_sof     = (state_q == ST_EMIT_LO) && (cnt_q == 8'd0);
    tx_eof     = tx_valid && last_byte;
    frame_len  = len_q;
    frame_done = (state_q == ST_DONE);
    frame_drop = drop_q;
    sync_err   = serr_q;
  end
endmodule
